// File: rtl/l2_flush_sequencer_pkg.sv
// Shared constants and types for the L2 flush sequencer.
package l2_flush_sequencer_pkg;

  localparam int L2_SET_BITS = 8;
  localparam int L2_WAY_BITS = 3;

  typedef logic [L2_SET_BITS-1:0] l2_set_t;
  typedef logic [L2_WAY_BITS-1:0] l2_way_t;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_ISSUE = 2'd1,
    FL_WAIT  = 2'd2,
    FL_DONE  = 2'd3
  } flush_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/l2_flush_cnt.sv
// Nested way/set walk counter; way is the inner loop, carry out of set ends the walk.
module l2_flush_cnt
  import l2_flush_sequencer_pkg::*;
#(
  parameter int SET_BITS = L2_SET_BITS,
  parameter int WAY_BITS = L2_WAY_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                incr,
  output logic [SET_BITS-1:0] set,
  output logic [WAY_BITS-1:0] way,
  output logic                last
);

  logic [WAY_BITS:0] r_way;
  logic [SET_BITS:0] r_set;
  logic [WAY_BITS:0] w_way_inc;
  logic [SET_BITS:0] w_set_inc;

  assign w_way_inc = {1'b0, r_way[WAY_BITS-1:0]} + {{WAY_BITS{1'b0}}, 1'b1};
  assign w_set_inc = {1'b0, r_set[SET_BITS-1:0]} + {{SET_BITS{1'b0}}, w_way_inc[WAY_BITS]};

  // Current pair is the last one when advancing it would carry out of set.
  assign last = w_set_inc[SET_BITS] & ~r_set[SET_BITS] & ~r_way[WAY_BITS];
  assign set  = r_set[SET_BITS-1:0];
  assign way  = r_way[WAY_BITS-1:0];

  // Walk counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_way <= {(WAY_BITS+1){1'b0}};
      r_set <= {(SET_BITS+1){1'b0}};
    end else if (clr) begin
      r_way <= {(WAY_BITS+1){1'b0}};
      r_set <= {(SET_BITS+1){1'b0}};
    end else if (incr) begin
      r_way <= w_way_inc[WAY_BITS] ? {(WAY_BITS+1){1'b0}} : w_way_inc;
      r_set <= w_set_inc;
    end else begin
      r_way <= r_way;
      r_set <= r_set;
    end
  end

endmodule

// File: rtl/l2_flush_sequencer.sv
// Full-cache flush sequencer walking every (set, way) pair through the L2 datapath.
// Optional statistics counters are enabled with L2_FLUSH_STATS_EN.
module l2_flush_sequencer
  import l2_flush_sequencer_pkg::*;
#(
  parameter int SET_BITS = L2_SET_BITS,
  parameter int WAY_BITS = L2_WAY_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_valid,
  output logic                flush_ready,
  input  logic                flush_all_i,
  output logic                step_valid,
  input  logic                step_ready,
  output logic [SET_BITS-1:0] step_set,
  output logic [WAY_BITS-1:0] step_way,
  output logic                step_all,
  input  logic                step_done,
  input  logic                stall,
  output logic                cpu_block,
  output logic                flush_done
`ifdef L2_FLUSH_STATS_EN
  ,output logic [SET_BITS+WAY_BITS:0] flush_lines_cnt
  ,output logic [31:0]                flush_cycles_cnt
`endif
);

  flush_state_t r_state;
  logic         r_flush_ready;
  logic         r_cpu_block;
  logic         r_flush_done;
  logic         r_step_all;
  logic         w_accept;
  logic         w_step_valid;
  logic         w_handshake;
  logic         w_advance;
  logic         w_last;

  assign w_accept     = (r_state == FL_IDLE) & r_flush_ready & flush_valid;
  // Stall must be able to withdraw a pending step in the same cycle it rises.
  assign w_step_valid = (r_state == FL_ISSUE) & ~stall;
  assign w_handshake  = w_step_valid & step_ready;
  assign w_advance    = (r_state == FL_WAIT) & step_done;

  assign flush_ready = r_flush_ready;
  assign step_valid  = w_step_valid;
  assign step_all    = r_step_all;
  assign cpu_block   = r_cpu_block;
  assign flush_done  = r_flush_done;

  l2_flush_cnt #(
    .SET_BITS (SET_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_accept),
    .incr (w_advance),
    .set  (step_set),
    .way  (step_way),
    .last (w_last)
  );

  // Flush control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= FL_IDLE;
      r_flush_ready <= 1'b0;
      r_cpu_block   <= 1'b0;
      r_flush_done  <= 1'b0;
      r_step_all    <= 1'b0;
    end else begin
      case (r_state)
        FL_IDLE: begin
          if (w_accept) begin
            r_state       <= FL_ISSUE;
            r_flush_ready <= 1'b0;
            r_cpu_block   <= 1'b1;
            r_step_all    <= flush_all_i;
          end else begin
            r_flush_ready <= 1'b1;
            r_cpu_block   <= 1'b0;
          end
        end
        FL_ISSUE: begin
          if (w_handshake) begin
            r_state <= FL_WAIT;
          end else begin
            r_state <= FL_ISSUE;
          end
        end
        FL_WAIT: begin
          if (w_advance && w_last) begin
            r_state      <= FL_DONE;
            r_flush_done <= 1'b1;
          end else if (w_advance) begin
            r_state <= FL_ISSUE;
          end else begin
            r_state <= FL_WAIT;
          end
        end
        FL_DONE: begin
          // Ready is raised here so a held command is taken on the first IDLE cycle.
          r_state       <= FL_IDLE;
          r_flush_done  <= 1'b0;
          r_cpu_block   <= 1'b0;
          r_flush_ready <= 1'b1;
        end
        default: begin
          r_state       <= FL_IDLE;
          r_flush_ready <= 1'b0;
          r_cpu_block   <= 1'b0;
          r_flush_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef L2_FLUSH_STATS_EN
  localparam int LW = SET_BITS + WAY_BITS + 1;

  logic [LW-1:0] r_lines;
  logic [31:0]   r_cycles;

  // Lines issued in the current or most recent flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lines <= {LW{1'b0}};
    end else if (w_accept) begin
      r_lines <= {LW{1'b0}};
    end else if (w_handshake) begin
      r_lines <= r_lines + LW'(1);
    end else begin
      r_lines <= r_lines;
    end
  end

  // Saturating count of cycles spent blocking the CPU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles <= 32'd0;
    end else if (r_cpu_block) begin
      r_cycles <= sat_inc32(r_cycles);
    end else begin
      r_cycles <= r_cycles;
    end
  end

  assign flush_lines_cnt  = r_lines;
  assign flush_cycles_cnt = r_cycles;
`endif

endmodule

// File: tb/tb_l2_flush_sequencer.sv
// Directed self-checking bench for l2_flush_sequencer with SET_BITS=2, WAY_BITS=1.
module tb_l2_flush_sequencer;

  localparam int SB = 2;
  localparam int WB = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_valid;
  logic          flush_ready;
  logic          flush_all_i;
  logic          step_valid;
  logic          step_ready;
  logic [SB-1:0] step_set;
  logic [WB-1:0] step_way;
  logic          step_all;
  logic          step_done;
  logic          stall;
  logic          cpu_block;
  logic          flush_done;
`ifdef L2_FLUSH_STATS_EN
  logic [SB+WB:0] flush_lines_cnt;
  logic [31:0]    flush_cycles_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  l2_flush_sequencer #(
    .SET_BITS (SB),
    .WAY_BITS (WB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_valid (flush_valid),
    .flush_ready (flush_ready),
    .flush_all_i (flush_all_i),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .step_set    (step_set),
    .step_way    (step_way),
    .step_all    (step_all),
    .step_done   (step_done),
    .stall       (stall),
    .cpu_block   (cpu_block),
    .flush_done  (flush_done)
`ifdef L2_FLUSH_STATS_EN
    ,.flush_lines_cnt  (flush_lines_cnt)
    ,.flush_cycles_cnt (flush_cycles_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample_counts();
    busy_cnt += int'(cpu_block);
    done_cnt += int'(flush_done);
  endtask

  // One ISSUE cycle with immediate acceptance followed by one WAIT cycle.
  task automatic step_pair(input int s, input int w);
    chk("issue_valid", 32'(step_valid), 32'd1);
    chk("issue_set", 32'(step_set), 32'(s));
    chk("issue_way", 32'(step_way), 32'(w));
    chk("walk_block", 32'(cpu_block), 32'd1);
    chk("walk_ready", 32'(flush_ready), 32'd0);
    sample_counts();
    tick();
    chk("wait_valid", 32'(step_valid), 32'd0);
    chk("wait_done", 32'(flush_done), 32'd0);
    sample_counts();
    tick();
  endtask

  initial begin
    rst         = 1'b0;
    flush_valid = 1'b0;
    flush_all_i = 1'b0;
    step_ready  = 1'b0;
    step_done   = 1'b0;
    stall       = 1'b0;
    repeat (3) tick();

    chk("rst_ready", 32'(flush_ready), 32'd0);
    chk("rst_valid", 32'(step_valid), 32'd0);
    chk("rst_set", 32'(step_set), 32'd0);
    chk("rst_way", 32'(step_way), 32'd0);
    chk("rst_all", 32'(step_all), 32'd0);
    chk("rst_block", 32'(cpu_block), 32'd0);
    chk("rst_done", 32'(flush_done), 32'd0);

    rst = 1'b1;
    tick();
    chk("idle_ready", 32'(flush_ready), 32'd1);
    chk("idle_block", 32'(cpu_block), 32'd0);

    // Full walk with ready and done always high.
    flush_valid = 1'b1;
    flush_all_i = 1'b1;
    step_ready  = 1'b1;
    step_done   = 1'b1;
    tick();
    flush_valid = 1'b0;
    chk("acc_all", 32'(step_all), 32'd1);
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step_pair(k / 2, k % 2);
    end
    chk("done_pulse", 32'(flush_done), 32'd1);
    chk("done_block", 32'(cpu_block), 32'd1);
    sample_counts();
    tick();
    chk("post_done", 32'(flush_done), 32'd0);
    chk("post_block", 32'(cpu_block), 32'd0);
    chk("post_ready", 32'(flush_ready), 32'd1);
    sample_counts();
    chk("busy_cycles", 32'(busy_cnt), 32'd17);
    chk("done_pulses", 32'(done_cnt), 32'd1);
`ifdef L2_FLUSH_STATS_EN
    chk("stats_lines", 32'(flush_lines_cnt), 32'd8);
    chk("stats_cycles", flush_cycles_cnt, 32'(busy_cnt));
`endif

    // Second walk: done held off, stall in ISSUE, command queued during walk.
    flush_valid = 1'b1;
    flush_all_i = 1'b0;
    tick();
    flush_valid = 1'b0;
    chk("walk2_all", 32'(step_all), 32'd0);
    step_pair(0, 0);
    step_pair(0, 1);
    step_pair(1, 0);
    chk("w11_valid", 32'(step_valid), 32'd1);
    chk("w11_set", 32'(step_set), 32'd1);
    chk("w11_way", 32'(step_way), 32'd1);
    step_done = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(step_valid), 32'd0);
      chk("hold_set", 32'(step_set), 32'd1);
      chk("hold_way", 32'(step_way), 32'd1);
      tick();
    end
    flush_valid = 1'b1;
    flush_all_i = 1'b1;
    step_done   = 1'b1;
    stall       = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(step_valid), 32'd0);
      chk("stall_set", 32'(step_set), 32'd2);
      chk("stall_way", 32'(step_way), 32'd0);
      chk("busy_ready", 32'(flush_ready), 32'd0);
      tick();
    end
    stall = 1'b0;
    #1;
    chk("resume_valid", 32'(step_valid), 32'd1);
    chk("resume_set", 32'(step_set), 32'd2);
    chk("resume_way", 32'(step_way), 32'd0);
    tick();
    chk("resume_wait", 32'(step_valid), 32'd0);
    tick();
    step_pair(2, 1);
    step_pair(3, 0);
    step_pair(3, 1);
    chk("walk2_done", 32'(flush_done), 32'd1);
    chk("walk2_done_all", 32'(step_all), 32'd0);
    chk("walk2_done_ready", 32'(flush_ready), 32'd0);
    tick();
    chk("held_ready", 32'(flush_ready), 32'd1);
    chk("held_block", 32'(cpu_block), 32'd0);
    chk("held_done", 32'(flush_done), 32'd0);
    tick();
    flush_valid = 1'b0;
    chk("walk3_all", 32'(step_all), 32'd1);
    chk("walk3_block", 32'(cpu_block), 32'd1);

    // Reset in the middle of the third walk.
    step_pair(0, 0);
    step_pair(0, 1);
    step_pair(1, 0);
    step_pair(1, 1);
    step_pair(2, 0);
    chk("pre_rst_set", 32'(step_set), 32'd2);
    chk("pre_rst_way", 32'(step_way), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(step_valid), 32'd0);
    chk("mid_rst_ready", 32'(flush_ready), 32'd0);
    chk("mid_rst_block", 32'(cpu_block), 32'd0);
    chk("mid_rst_all", 32'(step_all), 32'd0);
    chk("mid_rst_set", 32'(step_set), 32'd0);
    chk("mid_rst_way", 32'(step_way), 32'd0);
    chk("mid_rst_done", 32'(flush_done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      done_cnt += int'(flush_done);
    end
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b1;
    tick();
    chk("rel_ready", 32'(flush_ready), 32'd1);
    flush_valid = 1'b1;
    flush_all_i = 1'b0;
    tick();
    flush_valid = 1'b0;
    chk("restart_valid", 32'(step_valid), 32'd1);
    chk("restart_set", 32'(step_set), 32'd0);
    chk("restart_way", 32'(step_way), 32'd0);
    chk("restart_all", 32'(step_all), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
